// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared PC-source codes, sequencer state encoding and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_EX  = 2'd1;
    localparam logic [1:0] PC_SRC_MEM = 2'd2;

    localparam int RD_W_DEF = 6;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_JMEM_WAIT = 1'b1
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side status inputs and PC/buffer control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int RD_W  = 6,
    parameter int CNT_W = 16
);
    logic [RD_W-1:0]  id_rs_addr;
    logic [RD_W-1:0]  id_rt_addr;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_memread;
    logic             ex_regwrt;
    logic [RD_W-1:0]  ex_rd;
    logic             ex_br_taken;
    logic             ex_jump;
    logic             ex_jumpmem;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_memread, ex_regwrt, ex_rd, ex_br_taken, ex_jump, ex_jumpmem,
        input  pc_en, pc_src, ifid_en, ifid_flush, idex_flush, busy, stall_count
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_memread, ex_regwrt, ex_rd, ex_br_taken, ex_jump, ex_jumpmem,
        output pc_en, pc_src, ifid_en, ifid_flush, idex_flush, busy, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator between ID sources and EX rd.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int RD_W = 6
) (
    input  wire logic [RD_W-1:0] rs_addr_i,
    input  wire logic [RD_W-1:0] rt_addr_i,
    input  wire logic            uses_rs_i,
    input  wire logic            uses_rt_i,
    input  wire logic            ex_memread_i,
    input  wire logic            ex_regwrt_i,
    input  wire logic [RD_W-1:0] ex_rd_i,
    output logic                 hazard_o
);
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = uses_rs_i && (rs_addr_i == ex_rd_i);
    assign w_rt_match = uses_rt_i && (rt_addr_i == ex_rd_i);
    assign hazard_o   = ex_memread_i && ex_regwrt_i && (w_rs_match || w_rt_match);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : PC / IF/ID / ID/EX sequencing for load-use stalls and EX transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int RD_W    = RD_W_DEF,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  bus
);
    localparam logic [3:0]       WAIT_INIT = 4'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    hz_state_e        state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       w_hazard;
    logic       w_pc_en;
    logic [1:0] w_pc_src;
    logic       w_ifid_en;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_busy;

    hazard_detect #(
        .RD_W (RD_W)
    ) u_detect (
        .rs_addr_i    (bus.id_rs_addr),
        .rt_addr_i    (bus.id_rt_addr),
        .uses_rs_i    (bus.id_uses_rs),
        .uses_rt_i    (bus.id_uses_rt),
        .ex_memread_i (bus.ex_memread),
        .ex_regwrt_i  (bus.ex_regwrt),
        .ex_rd_i      (bus.ex_rd),
        .hazard_o     (w_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        w_pc_en      = 1'b1;
        w_pc_src     = PC_SRC_SEQ;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_busy       = 1'b0;

        // Reset wins combinationally so an in-flight jumpmem fetch is dropped at once.
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.ex_jumpmem) begin
                        w_pc_en      = 1'b0;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        state_d      = ST_JMEM_WAIT;
                        wcnt_d       = WAIT_INIT;
                    end else if (bus.ex_jump || bus.ex_br_taken) begin
                        w_pc_src     = PC_SRC_EX;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_hazard) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
                ST_JMEM_WAIT: begin
                    w_busy       = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (wcnt_q != 4'd0) begin
                        w_pc_en = 1'b0;
                        wcnt_d  = wcnt_q - 4'd1;
                    end else begin
                        w_pc_src = PC_SRC_MEM;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    wcnt_d  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!w_pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.pc_src      = w_pc_src;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.busy        = w_busy;
    assign bus.stall_count = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed + random bench for hazard_ctrl against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int RD_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [RD_W-1:0] rs_a, rt_a, rd_a;
    logic u_rs, u_rt, mrd, rwr, brt, jmp, jmem;

    hazard_ctrl_if #(.RD_W(RD_W), .CNT_W(16)) bus   ();
    hazard_ctrl_if #(.RD_W(RD_W), .CNT_W(4))  bus_s ();

    assign bus.id_rs_addr    = rs_a;  assign bus_s.id_rs_addr  = rs_a;
    assign bus.id_rt_addr    = rt_a;  assign bus_s.id_rt_addr  = rt_a;
    assign bus.id_uses_rs    = u_rs;  assign bus_s.id_uses_rs  = u_rs;
    assign bus.id_uses_rt    = u_rt;  assign bus_s.id_uses_rt  = u_rt;
    assign bus.ex_memread    = mrd;   assign bus_s.ex_memread  = mrd;
    assign bus.ex_regwrt     = rwr;   assign bus_s.ex_regwrt   = rwr;
    assign bus.ex_rd         = rd_a;  assign bus_s.ex_rd       = rd_a;
    assign bus.ex_br_taken   = brt;   assign bus_s.ex_br_taken = brt;
    assign bus.ex_jump       = jmp;   assign bus_s.ex_jump     = jmp;
    assign bus.ex_jumpmem    = jmem;  assign bus_s.ex_jumpmem  = jmem;

    hazard_ctrl #(.RD_W(RD_W), .MEM_LAT(2), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    hazard_ctrl #(.RD_W(RD_W), .MEM_LAT(3), .CNT_W(4)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s)
    );

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       ifid_en;
        logic       ifid_flush;
        logic       idex_flush;
        logic       busy;
    } ctl_t;

    // Reference: cycles of memory wait remaining, and stall count, per instance.
    int m_wait  [2];
    int m_stall [2];
    int m_lat   [2] = '{2, 3};
    int m_max   [2] = '{65535, 15};

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ctl_t model(input int k);
        ctl_t c;
        logic hz;
        c = '{pc_en: 1'b1, pc_src: 2'd0, ifid_en: 1'b1, ifid_flush: 1'b0,
              idex_flush: 1'b0, busy: 1'b0};
        if (rst) return c;
        hz = mrd && rwr && ((u_rs && rs_a == rd_a) || (u_rt && rt_a == rd_a));
        if (m_wait[k] > 0) begin
            c.busy       = 1'b1;
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
            c.pc_en      = (m_wait[k] == 1);
            c.pc_src     = (m_wait[k] == 1) ? 2'd2 : 2'd0;
        end else if (jmem) begin
            c.pc_en = 1'b0; c.ifid_flush = 1'b1; c.idex_flush = 1'b1;
        end else if (jmp || brt) begin
            c.pc_src = 2'd1; c.ifid_flush = 1'b1; c.idex_flush = 1'b1;
        end else if (hz) begin
            c.pc_en = 1'b0; c.ifid_en = 1'b0; c.idex_flush = 1'b1;
        end
        return c;
    endfunction

    task automatic check_all(input string tag);
        ctl_t e0, e1;
        e0 = model(0);
        e1 = model(1);
        chk({tag, ".pc_en"},      int'(bus.pc_en),        int'(e0.pc_en));
        chk({tag, ".pc_src"},     int'(bus.pc_src),       int'(e0.pc_src));
        chk({tag, ".ifid_en"},    int'(bus.ifid_en),      int'(e0.ifid_en));
        chk({tag, ".ifid_flush"}, int'(bus.ifid_flush),   int'(e0.ifid_flush));
        chk({tag, ".idex_flush"}, int'(bus.idex_flush),   int'(e0.idex_flush));
        chk({tag, ".busy"},       int'(bus.busy),         int'(e0.busy));
        chk({tag, ".stall"},      int'(bus.stall_count),  m_stall[0]);
        chk({tag, ".s.pc_en"},    int'(bus_s.pc_en),      int'(e1.pc_en));
        chk({tag, ".s.pc_src"},   int'(bus_s.pc_src),     int'(e1.pc_src));
        chk({tag, ".s.busy"},     int'(bus_s.busy),       int'(e1.busy));
        chk({tag, ".s.flush"},    int'({bus_s.ifid_en, bus_s.ifid_flush, bus_s.idex_flush}),
                                  int'({e1.ifid_en, e1.ifid_flush, e1.idex_flush}));
        chk({tag, ".s.stall"},    int'(bus_s.stall_count), m_stall[1]);
    endtask

    // Inputs are set at the falling edge; check mid-cycle, then advance the model.
    task automatic step(input string tag);
        ctl_t e [2];
        #2;
        check_all(tag);
        for (int k = 0; k < 2; k++) e[k] = model(k);
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (!e[k].pc_en && m_stall[k] < m_max[k]) m_stall[k]++;
                if (m_wait[k] > 0)  m_wait[k]--;
                else if (jmem)      m_wait[k] = m_lat[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_a = '0; rt_a = '0; rd_a = '0;
        u_rs = 0; u_rt = 0; mrd = 0; rwr = 0; brt = 0; jmp = 0; jmem = 0;
    endtask

    task automatic load_use(input logic use_rt);
        idle_inputs();
        mrd = 1; rwr = 1; rd_a = 6'd5; u_rt = use_rt; rt_a = 6'd5; rs_a = 6'd9; u_rs = 1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_wait[k] = 0; m_stall[k] = 0; end
        idle_inputs();
        jmem = 1;
        rst  = 1;
        #1;
        chk("rst.pc_en",  int'(bus.pc_en), 1);
        chk("rst.pc_src", int'(bus.pc_src), 0);
        chk("rst.busy",   int'(bus.busy), 0);
        chk("rst.stall",  int'(bus.stall_count), 0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        step("idle");

        load_use(1'b1);
        step("lu");
        idle_inputs();
        chk("lu.stall_after", int'(bus.stall_count), 1);
        step("lu_clear");
        load_use(1'b0);
        step("lu_nort");
        chk("lu_nort.stall", int'(bus.stall_count), 1);

        load_use(1'b1);
        brt = 1;
        step("br_hz");
        chk("br_hz.stall", int'(bus.stall_count), 1);
        idle_inputs();

        for (int pass = 0; pass < 2; pass++) begin
            jmem = 1;
            chk("jm.c0.busy", int'(bus.busy), 0);
            step("jm0");
            for (int c = 1; c <= 3; c++) begin
                if (pass == 1) begin
                    load_use(c[0]);
                    jmp = c[1]; brt = c[0]; jmem = c[0];
                end else begin
                    idle_inputs();
                end
                if (c == 2) begin
                    #1;
                    chk("jm.c2.pc_src", int'(bus.pc_src), 2);
                    chk("jm.c2.busy",   int'(bus.busy), 1);
                    #(-1 + 1);
                end
                step("jmw");
            end
            idle_inputs();
            step("jm_done");
        end

        load_use(1'b1);
        for (int c = 0; c < 20; c++) step("sat");
        chk("sat.s.stall", int'(bus_s.stall_count), 15);
        idle_inputs();

        for (int c = 0; c < 400; c++) begin
            rs_a = 6'($urandom_range(0, 7)); rt_a = 6'($urandom_range(0, 7));
            rd_a = 6'($urandom_range(0, 7));
            u_rs = 1'($urandom); u_rt = 1'($urandom);
            mrd  = ($urandom_range(0, 3) != 0); rwr = ($urandom_range(0, 3) != 0);
            brt  = ($urandom_range(0, 7) == 0); jmp = ($urandom_range(0, 9) == 0);
            jmem = ($urandom_range(0, 11) == 0);
            step("rnd");
        end

        idle_inputs();
        jmem = 1;
        step("abort_jm");
        chk("abort.pre_busy", int'(bus.busy), 1);
        #2;
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin m_wait[k] = 0; m_stall[k] = 0; end
        chk("abort.pc_en",  int'(bus.pc_en), 1);
        chk("abort.pc_src", int'(bus.pc_src), 0);
        chk("abort.busy",   int'(bus.busy), 0);
        chk("abort.stall",  int'(bus.stall_count), 0);
        chk("abort.s.busy", int'(bus_s.busy), 0);
        @(negedge clk);
        step("abort_hold");
        rst = 0;
        idle_inputs();
        step("post_rst");
        load_use(1'b1);
        step("post_lu");
        idle_inputs();
        step("post_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
